// File: rtl/vec_alu_sequencer.sv
// Sequences an L-element vector operation through an external combinational scalar ALU,
// one element per clock, and assembles the result vector plus per-element div-by-zero flags.
module vec_alu_sequencer #(
  parameter int unsigned N = 20,
  parameter int unsigned L = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L*N-1:0] in_a,
  input  logic [L*N-1:0] in_b,
  input  logic [2:0]     in_f,
  input  logic           in_bcast,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [2:0]     alu_f,
  input  logic [N-1:0]   alu_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [L*N-1:0] out_result,
  output logic [L-1:0]   out_divz
);

  localparam int unsigned IdxW = $clog2(L);
  localparam logic [2:0]  OpDiv = 3'b100;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [L*N-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]      f_q, f_d;
  logic            bcast_q, bcast_d;
  logic [L-1:0]    divz_q, divz_d;

  logic [N-1:0]    a_elem [L];
  logic [N-1:0]    b_elem [L];
  logic [N-1:0]    op_a, op_b;
  logic            last;

  for (genvar i = 0; i < L; i++) begin : g_unpack
    assign a_elem[i] = a_q[i*N +: N];
    assign b_elem[i] = b_q[i*N +: N];
  end

  assign op_a = a_elem[idx_q];
  assign op_b = bcast_q ? b_elem[0] : b_elem[idx_q];
  assign last = (idx_q == IdxW'(L - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      bcast_q  <= 1'b0;
      result_q <= '0;
      divz_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      bcast_q  <= bcast_d;
      result_q <= result_d;
      divz_q   <= divz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Datapath: operands latched on acceptance, one result element written per RUN edge.
  always_comb begin
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    f_d      = f_q;
    bcast_d  = bcast_q;
    result_d = result_q;
    divz_d   = divz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          f_d     = in_f;
          bcast_d = in_bcast;
          idx_d   = '0;
          divz_d  = '0;
        end
      end
      StRun: begin
        for (int i = 0; i < L; i++) begin
          if (idx_q == IdxW'(i)) begin
            result_d[i*N +: N] = alu_result;
            divz_d[i]          = (f_q == OpDiv) && (op_b == '0);
          end
        end
        if (!last) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    alu_a     = '0;
    alu_b     = '0;
    alu_f     = '0;
    if (state_q == StRun) begin
      alu_a = op_a;
      alu_b = op_b;
      alu_f = f_q;
    end
  end

  assign out_result = result_q;
  assign out_divz   = divz_q;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: directed vector table, randomized ops against an element-wise
// reference model, plus stall and mid-operation reset sequences.
module tb_vec_alu_sequencer;

  localparam int unsigned N = 20;
  localparam int unsigned L = 4;
  typedef logic [L*N-1:0] vec_t;

  typedef struct {
    vec_t         a;
    vec_t         b;
    logic [2:0]   f;
    logic         bc;
    vec_t         er;
    logic [L-1:0] edz;
  } vec_rec_t;

  logic         clk, rst_n;
  logic         in_valid, in_ready, in_bcast;
  vec_t         in_a, in_b;
  logic [2:0]   in_f;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_f;
  logic         out_valid, out_ready;
  vec_t         out_result;
  logic [L-1:0] out_divz;

  int checks = 0;
  int errors = 0;

  vec_alu_sequencer #(.N(N), .L(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_f       (in_f),
    .in_bcast   (in_bcast),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_divz   (out_divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar ALU attached to the sequencer; div by zero returns all ones.
  function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] f);
    logic [2*N-1:0] p;
    p = a * b;
    case (f)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return b;
      3'b100:  return (b == '0) ? '1 : a / b;
      3'b101:  return N'(a < b) | (N'(a == b) << 1);
      default: return p[N-1:0];
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_f);

  function automatic logic [N-1:0] el(input vec_t v, input int i);
    return v[i*N +: N];
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < L; i++) v[i*N +: N] = N'($urandom);
    return v;
  endfunction

  task automatic model(input vec_t a, input vec_t b, input logic [2:0] f, input logic bc,
                       output vec_t r, output logic [L-1:0] dz);
    logic [N-1:0] eb;
    r  = '0;
    dz = '0;
    for (int i = 0; i < L; i++) begin
      eb = bc ? el(b, 0) : el(b, i);
      r[i*N +: N] = alu_fn(el(a, i), eb, f);
      dz[i]       = (f == 3'b100) && (eb == '0);
    end
  endtask

  task automatic chk(input string name, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Runs one op; scrambles the inputs while it is in flight and checks the ALU operands.
  task automatic do_op(input vec_t a, input vec_t b, input logic [2:0] f, input logic bc,
                       output vec_t r, output logic [L-1:0] dz);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", vec_t'(in_ready), vec_t'(1));
    in_a = a; in_b = b; in_f = f; in_bcast = bc; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      in_a = rnd_vec(); in_b = rnd_vec(); in_f = 3'($urandom); in_bcast = 1'($urandom);
      in_valid = 1'($urandom);
      if (lat < L) begin
        chk("alu_a", vec_t'(alu_a), vec_t'(el(a, lat)));
        chk("alu_b", vec_t'(alu_b), vec_t'(el(b, bc ? 0 : lat)));
        chk("alu_f", vec_t'(alu_f), vec_t'(f));
      end
      @(posedge clk); lat++; @(negedge clk);
    end
    in_valid = 1'b0;
    chk("latency", vec_t'(lat), vec_t'(L));
    chk("alu_zero_done", vec_t'({alu_a, alu_b, alu_f}), '0);
    r  = out_result;
    dz = out_divz;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after", vec_t'(in_ready), vec_t'(1));
    chk("out_valid_after", vec_t'(out_valid), '0);
  endtask

  initial begin
    vec_rec_t     tbl[8];
    vec_t         r, er, a, b, na, nb;
    logic [L-1:0] dz, edz;
    logic [2:0]   f;
    logic         bc, seen;
    int           lat;

    tbl[0] = '{{20'd4, 20'd3, 20'd2, 20'd1}, {20'd40, 20'd30, 20'd20, 20'd10}, 3'b000, 1'b0,
               {20'd44, 20'd33, 20'd22, 20'd11}, 4'b0000};
    tbl[1] = '{{20'd4, 20'd3, 20'd2, 20'd1}, {20'd7, 20'd7, 20'd7, 20'd5}, 3'b011, 1'b1,
               {20'd20, 20'd15, 20'd10, 20'd5}, 4'b0000};
    tbl[2] = '{{20'd7, 20'd6, 20'd9, 20'd8}, {20'd0, 20'd3, 20'd0, 20'd2}, 3'b100, 1'b0,
               {20'hFFFFF, 20'd2, 20'hFFFFF, 20'd4}, 4'b1010};
    tbl[3] = '{{20'd40, 20'd30, 20'd20, 20'd0}, {20'd4, 20'd3, 20'd2, 20'd1}, 3'b001, 1'b0,
               {20'd36, 20'd27, 20'd18, 20'hFFFFF}, 4'b0000};
    tbl[4] = '{{20'd1, 20'd1, 20'd1, 20'd1}, {20'd9, 20'd8, 20'd7, 20'd6}, 3'b010, 1'b0,
               {20'd9, 20'd8, 20'd7, 20'd6}, 4'b0000};
    tbl[5] = '{{20'd7, 20'd6, 20'd9, 20'd8}, {20'd3, 20'd3, 20'd3, 20'd0}, 3'b100, 1'b1,
               {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF}, 4'b1111};
    tbl[6] = '{{20'd1, 20'd1, 20'd1, 20'h80000}, {20'd3, 20'd3, 20'd3, 20'd2}, 3'b111, 1'b0,
               {20'd3, 20'd3, 20'd3, 20'd0}, 4'b0000};
    tbl[7] = '{{20'd0, 20'd9, 20'd5, 20'd1}, {20'd0, 20'd3, 20'd5, 20'd2}, 3'b101, 1'b0,
               {20'd2, 20'd0, 20'd2, 20'd1}, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_f = '0; in_bcast = 1'b0;
    #12;
    chk("rst_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("rst_out_valid", vec_t'(out_valid), '0);
    chk("rst_out_result", out_result, '0);
    chk("rst_out_divz", vec_t'(out_divz), '0);
    chk("rst_alu", vec_t'({alu_a, alu_b, alu_f}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", vec_t'(in_ready), vec_t'(1));

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].bc, r, dz);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].er);
      chk($sformatf("tbl%0d_divz", i), vec_t'(dz), vec_t'(tbl[i].edz));
    end

    for (int i = 0; i < 40; i++) begin
      a = rnd_vec();
      b = rnd_vec();
      for (int e = 0; e < L; e++) if ($urandom_range(3) == 0) b[e*N +: N] = '0;
      f  = 3'($urandom);
      bc = 1'($urandom);
      model(a, b, f, bc, er, edz);
      do_op(a, b, f, bc, r, dz);
      chk($sformatf("rnd%0d_result", i), r, er);
      chk($sformatf("rnd%0d_divz", i), vec_t'(dz), vec_t'(edz));
    end

    // Consumer stall with a competing request pending.
    a = tbl[0].a; b = tbl[0].b;
    model(a, b, 3'b000, 1'b0, er, edz);
    na = {20'd100, 20'd200, 20'd300, 20'd400};
    nb = {20'd7, 20'd7, 20'd7, 20'd3};
    @(negedge clk);
    in_a = a; in_b = b; in_f = 3'b000; in_bcast = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("stall_latency", vec_t'(lat), vec_t'(L));
    in_a = na; in_b = nb; in_f = 3'b001; in_bcast = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      chk("stall_result", out_result, er);
      chk("stall_out_valid", vec_t'(out_valid), vec_t'(1));
      chk("stall_in_ready", vec_t'(in_ready), '0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_in_ready", vec_t'(in_ready), vec_t'(1));
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("stall_new_accepted", vec_t'(in_ready), '0);
    model(na, nb, 3'b001, 1'b1, er, edz);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("stall_new_latency", vec_t'(lat), vec_t'(L));
    chk("stall_new_result", out_result, er);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after two RUN edges discards the op.
    @(negedge clk);
    in_a = tbl[1].a; in_b = tbl[0].b; in_f = 3'b011; in_bcast = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", vec_t'(in_ready), vec_t'(1));
    chk("midrst_out_valid", vec_t'(out_valid), '0);
    chk("midrst_out_result", out_result, '0);
    chk("midrst_out_divz", vec_t'(out_divz), '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_out_valid", vec_t'(seen), '0);
    do_op(tbl[0].a, tbl[0].b, tbl[0].f, tbl[0].bc, r, dz);
    chk("postrst_result", r, tbl[0].er);
    chk("postrst_divz", vec_t'(dz), vec_t'(tbl[0].edz));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
